// File: rtl/ssm_mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// default geometry/latency constants and the even-parity helper.
package ssm_mem_pkg;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_DATA_W      = 16;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  // Wait counter is wide enough for the largest legal latency (15).
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Even parity: the returned bit makes the total count of ones even.
  // Callers zero-extend their word to 64 bits, which leaves the result unchanged.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word storage with a registered read port.
// Contents are never reset; only the read register is cleared by reset,
// so the read-data output starts at zero and holds between reads.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Storage write: no reset, so contents survive reset and start undefined.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register: loads only on a read strobe and otherwise holds its value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the MAR/MDR side: accepts one request at a time,
// waits WAIT_CYCLES cycles in BUSY, performs the access, and pulses
// MEM_done for one DONE cycle.
// Optional build macro: MEM_PARITY_EN (adds one stored even-parity bit per word).
//
// Handshake: a request is accepted on a rising edge where MEM_ready=1 and
// MEM_req=1. MEM_ready is high only in IDLE. All request inputs are latched
// at acceptance and ignored until the FSM is back in IDLE; nothing is queued.
// MEM_done marks the single cycle in which MEM_dataout and MEM_parity_err
// describe the completed access.
module mem_responder
  import ssm_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              MEM_clock,
  input  logic              MEM_reset_n,
  input  logic              MEM_req,
  input  logic              MEM_we,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_datain,
  output logic [DATA_W-1:0] MEM_dataout,
  output logic              MEM_ready,
  output logic              MEM_done,
  output logic              MEM_parity_err,
  output logic [1:0]        MEM_state_dbg
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              last_busy;
  logic              arr_we;
  logic              arr_re;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic              rd_parity_bad;

  // The access happens on the edge that ends the final BUSY cycle.
  assign last_busy = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);
  assign arr_we    = last_busy && we_q;
  assign arr_re    = last_busy && !we_q;

`ifdef MEM_PARITY_EN
  assign arr_wdata     = {even_parity(64'(data_q)), data_q};
  assign rd_parity_bad = even_parity(64'(arr_rdata[DATA_W-1:0])) != arr_rdata[DATA_W];
`else
  assign arr_wdata     = data_q;
  assign rd_parity_bad = 1'b0;
`endif

  // State register plus latched request fields and the wait counter.
  always_ff @(posedge MEM_clock or negedge MEM_reset_n) begin
    if (!MEM_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: latch on acceptance, count BUSY cycles, single DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (MEM_req) begin
          state_d = ST_BUSY;
          cnt_d   = '0;
          we_d    = MEM_we;
          addr_d  = MEM_addr;
          data_d  = MEM_datain;
        end
      end
      ST_BUSY: begin
        if (last_busy) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    MEM_ready      = 1'b0;
    MEM_done       = 1'b0;
    MEM_parity_err = 1'b0;
    unique case (state_q)
      ST_IDLE: MEM_ready = 1'b1;
      ST_DONE: begin
        MEM_done       = 1'b1;
        MEM_parity_err = !we_q && rd_parity_bad;
      end
      default: ;
    endcase
  end

  assign MEM_dataout   = arr_rdata[DATA_W-1:0];
  assign MEM_state_dbg = state_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clk_i   (MEM_clock),
    .rst_ni  (MEM_reset_n),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (addr_q),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, write/read, input changes during
// BUSY, reset abort, back-to-back requests and the parity flag.
module tb_mem_responder;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WC = 2;

  // Clock / reset / DUT signals
  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          req   = 1'b0;
  logic          we    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout;
  logic          ready;
  logic          done;
  logic          perr;
  logic [1:0]    st;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_CYCLES (WC)
  ) dut (
    .MEM_clock      (clk),
    .MEM_reset_n    (rst_n),
    .MEM_req        (req),
    .MEM_we         (we),
    .MEM_addr       (addr),
    .MEM_datain     (din),
    .MEM_dataout    (dout),
    .MEM_ready      (ready),
    .MEM_done       (done),
    .MEM_parity_err (perr),
    .MEM_state_dbg  (st)
  );

  // Scoreboard state
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access; optionally changes addr/data during BUSY.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic exp_perr, input bit disturb);
    int            cyc;
    int            guard;
    logic [DW-1:0] e;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", ready, 1);
    req  = 1'b1;
    we   = w;
    addr = a;
    din  = d;
    if (!w) exp_q.push_back(model[a]);
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    chk("ready_low_busy", ready, 0);
    if (disturb) begin
      addr = 8'h20;
      din  = 16'h1234;
    end
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, WC + 1);
    chk("done_seen", done, 1);
    chk("ready_in_done", ready, 0);
    if (!w) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", dout, e);
        last_rd = e;
      end
    end else begin
      chk("wr_keeps_dout", dout, last_rd);
      model[a] = d;
    end
    chk("parity_err", perr, exp_perr);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_after", ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int cyc;
    int last_done;
    int done_cnt;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_perr", perr, 0);
    chk("rst_dout", dout, 16'h0000);
    chk("rst_state", st, 2'd0);
    rst_n = 1'b1;

    // Write then read back
    access(1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0);
    access(1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);

    // Inputs changed during BUSY must not redirect the access
    access(1'b1, 8'h20, 16'h0F0F, 1'b0, 1'b0);
    access(1'b1, 8'h10, 16'hA5A5, 1'b0, 1'b1);
    access(1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);
    access(1'b0, 8'h20, 16'h0000, 1'b0, 1'b0);
    chk("busy_change_ignored", (last_rd != 16'h1234), 1);
    access(1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0);

    // Reset during BUSY of a write aborts it
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b1;
    addr = 8'h10;
    din  = 16'h5555;
    @(negedge clk);
    req = 1'b0;
    chk("abort_in_busy", st, 2'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_state", st, 2'd0);
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_dout", dout, 16'h0000);
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    access(1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);

    // Back-to-back writes with MEM_req held high
    @(negedge clk);
    req  = 1'b1;
    we   = 1'b1;
    addr = 8'h00;
    din  = 16'hC000;
    k = 0;
    cyc = 0;
    last_done = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (k == 0) chk("b2b_first", cyc, WC + 1);
        else        chk("b2b_spacing", cyc - last_done, WC + 2);
        chk("b2b_dout_held", dout, last_rd);
        model[k] = 16'hC000 + 16'(k);
        last_done = cyc;
        k++;
        if (k < 4) begin
          addr = 8'(k);
          din  = 16'hC000 + 16'(k);
        end else begin
          req = 1'b0;
        end
      end
    end
    chk("b2b_count", k, 4);
    for (int i = 0; i < 4; i++) access(1'b0, 8'(i), 16'h0000, 1'b0, 1'b0);

    // Parity: corrupt a stored bit when parity is built in
`ifdef MEM_PARITY_EN
    dut.u_array.mem_q[16][0] = ~dut.u_array.mem_q[16][0];
    model[16][0] = ~model[16][0];
    access(1'b0, 8'h10, 16'h0000, 1'b1, 1'b0);
`else
    access(1'b0, 8'h10, 16'h0000, 1'b0, 1'b0);
`endif

    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16: word width, matching the MDR data path.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: access latency in BUSY cycles; legal range 1..15.
REQ-004 SHALL have port MEM_clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port MEM_reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port MEM_req, input, 1: access request from the MAR/MDR side.
REQ-007 SHALL have port MEM_we, input, 1: 1 = write, 0 = read; sampled with MEM_req.
REQ-008 SHALL have port MEM_addr, input, ADDR_W: word address from the MAR.
REQ-009 SHALL have port MEM_datain, input, DATA_W: write data from MDR_data_to_memory.
REQ-010 SHALL have port MEM_dataout, output, DATA_W: read data to MDR_data_from_memory.
REQ-011 SHALL have port MEM_ready, output, 1: high only in IDLE; a request is accepted only then.
REQ-012 SHALL have port MEM_done, output, 1: one-cycle completion pulse.
REQ-013 SHALL have port MEM_parity_err, output, 1: read parity mismatch flag, valid with MEM_done.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 In IDLE with MEM_req=1 at an edge, SHALL latch MEM_we, MEM_addr and MEM_datain, clear the wait counter, and go to BUSY.
REQ-016 SHALL ignore MEM_req and input changes in BUSY and DONE, with no queuing; the latched values govern the access.
REQ-017 SHALL remain in BUSY for exactly WAIT_CYCLES cycles.
REQ-018 On the final BUSY edge, SHALL write the latched data to the array for a write, or load the array word into MEM_dataout for a read, then enter DONE.
REQ-019 SHALL assert MEM_done for exactly the one DONE cycle, then return to IDLE on the next edge.
REQ-020 SHALL make the request-to-done latency WAIT_CYCLES+1 edges after acceptance, with MEM_ready low throughout.
REQ-021 SHALL hold MEM_dataout at its last read value between reads; writes never change it.
REQ-022 A read following a write to the same address SHALL return the newly written data.
REQ-023 A request held high across DONE SHALL be accepted on the first IDLE edge, giving back-to-back accesses every WAIT_CYCLES+2 cycles.
REQ-024 Array contents SHALL NOT be reset; reading an unwritten word returns undefined data.

Reset
REQ-025 While MEM_reset_n=0, SHALL force state IDLE, counter 0, MEM_dataout 0, MEM_done 0, MEM_parity_err 0 and MEM_ready 1.
REQ-026 Reset asserted in BUSY SHALL abort the access, and an aborted write SHALL NOT modify the array.
REQ-027 After reset release, the first edge with MEM_req=1 SHALL be accepted.

Configuration
REQ-028 With macro MEM_PARITY_EN defined, SHALL store one even-parity bit per word on write and recompute it on read, asserting MEM_parity_err with MEM_done on mismatch.
REQ-029 Without MEM_PARITY_EN, the parity storage SHALL be absent and MEM_parity_err SHALL be tied to 0; the port list is identical in both builds.

Structure
REQ-030 Package ssm_mem_pkg SHALL hold the FSM state enum, the default ADDR_W/DATA_W/WAIT_CYCLES constants, and the parity helper function.
REQ-031 Sub-module mem_array SHALL hold the synchronous single-port storage (write enable, address, write data, registered read); the FSM and counter stay in mem_responder.

Verification
REQ-032 Reset, then write 0xBEEF to address 0x10 with WAIT_CYCLES=2 -> MEM_ready low 3 cycles, MEM_done pulses at edge 3, MEM_dataout stays 0x0000.
REQ-033 Read address 0x10 -> MEM_dataout=0xBEEF with MEM_done, MEM_parity_err=0.
REQ-034 During BUSY, change MEM_addr to 0x20 and MEM_datain to 0x1234 -> the access still targets 0x10; a later read of 0x20 does not return 0x1234.
REQ-035 Pull MEM_reset_n low in BUSY of a write of 0x5555 to 0x10 -> state returns to IDLE, no MEM_done, a later read of 0x10 returns 0xBEEF.
REQ-036 Hold MEM_req high continuously for writes to 0x00..0x03 -> one MEM_done every 4 cycles, and read-back matches.
REQ-037 With MEM_PARITY_EN, force-flip a stored data bit of 0x10, then read -> MEM_parity_err=1 with MEM_done; without the macro -> MEM_parity_err=0.
